aud_sample_pacer: RTL and testbench

- Upstream feeder for the audio PWM modulator.
- Buffers PCM samples pushed by the bus side (APB register writes) in a small FIFO.
- Releases exactly one sample per programmable sample period to the modulator over a valid/ready handshake.
- Flags underrun (tick with empty FIFO) and late consumer (tick while the previous sample is still unaccepted).

---
 rtl/aud_pkg.sv | 14 +
 rtl/aud_sync_fifo.sv | 57 +++++
 rtl/aud_sample_pacer.sv | 135 +++++++++++++
 tb/tb_aud_sample_pacer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared audio-path definitions: pacer state encoding and default widths
// used by the pacer, the APB wrapper and the PWM modulator.
package aud_pkg;

  localparam int AUD_DATA_W = 8;
  localparam int AUD_DIV_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    OFFER = 2'd2
  } pacer_state_t;

endpackage

// File: rtl/aud_sync_fifo.sv
// Single-clock sample FIFO with occupancy count and synchronous flush.
// Pushes into a full FIFO and pops from an empty one are ignored.
module aud_sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem[rd_ptr_q];

  // flush wins over any same-cycle push or pop
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge pclk_i) begin
    if (prst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge pclk_i) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/aud_sample_pacer.sv
// Paces buffered PCM samples to the PWM modulator: one valid/ready offer per
// programmable sample period, with sticky underrun and late-consumer flags.
//
// state | meaning
// IDLE  | disabled, divider cleared, FIFO contents kept
// WAIT  | divider running, waiting for the next tick
// OFFER | head sample presented, waiting for smp_ready_i
module aud_sample_pacer
  import aud_pkg::*;
#(
  parameter  int DATA_W = AUD_DATA_W,
  parameter  int DEPTH  = 16,
  parameter  int DIV_W  = AUD_DIV_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              smp_valid_o,
  output logic [DATA_W-1:0] smp_data_o,
  input  logic              smp_ready_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              underrun_o,
  output logic              late_o,
  input  logic              flags_clr_i,
  output logic              busy_o
);

  pacer_state_t      state_q;
  pacer_state_t      state_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              underrun_q;
  logic              late_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tick;
  logic              hs;
  logic              load_data;
  logic              underrun_set;
  logic              late_set;

  aud_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .flush_i     (flush_i),
    .push_i      (wr_valid_i),
    .push_data_i (wr_data_i),
    .pop_i       (hs),
    .head_o      (fifo_head),
    .level_o     (level_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign tick = en_i && (state_q != IDLE) && (cnt_q == '0);
  assign hs   = (state_q == OFFER) && smp_ready_i;

  always_comb begin
    state_d      = state_q;
    load_data    = 1'b0;
    underrun_set = 1'b0;
    late_set     = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          // a tick coinciding with a flush neither offers nor flags
          if (tick && !flush_i) begin
            if (!fifo_empty) begin
              state_d   = OFFER;
              load_data = 1'b1;
            end else begin
              underrun_set = 1'b1;
            end
          end
        end
        OFFER: begin
          if (flush_i || hs) state_d = WAIT;
          else if (tick)     late_set = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i || !en_i)                    cnt_q <= '0;
    else if (state_q == IDLE || cnt_q == '0) cnt_q <= div_i;
    else                                    cnt_q <= cnt_q - DIV_W'(1);
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i)         data_q <= '0;
    else if (load_data) data_q <= fifo_head;
  end

  // set beats a same-cycle clear
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      if (underrun_set)     underrun_q <= 1'b1;
      else if (flags_clr_i) underrun_q <= 1'b0;
      if (late_set)         late_q <= 1'b1;
      else if (flags_clr_i) late_q <= 1'b0;
    end
  end

  assign wr_ready_o  = !fifo_full;
  assign smp_valid_o = (state_q == OFFER);
  assign smp_data_o  = data_q;
  assign underrun_o  = underrun_q;
  assign late_o      = late_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_aud_sample_pacer.sv
// Directed bench for aud_sample_pacer; samples handed over on the handshake
// are compared against a queue of expected samples by a separate monitor.
module tb_aud_sample_pacer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 16;
  localparam int LVL_W  = 5;

  logic              pclk_i = 1'b0;
  logic              prst_i;
  logic              en_i;
  logic              flush_i;
  logic [DIV_W-1:0]  div_i;
  logic              wr_valid_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              smp_valid_o;
  logic [DATA_W-1:0] smp_data_o;
  logic              smp_ready_i;
  logic [LVL_W-1:0]  level_o;
  logic              underrun_o;
  logic              late_o;
  logic              flags_clr_i;
  logic              busy_o;

  aud_sample_pacer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .en_i        (en_i),
    .flush_i     (flush_i),
    .div_i       (div_i),
    .wr_valid_i  (wr_valid_i),
    .wr_data_i   (wr_data_i),
    .wr_ready_o  (wr_ready_o),
    .smp_valid_o (smp_valid_o),
    .smp_data_o  (smp_data_o),
    .smp_ready_i (smp_ready_i),
    .level_o     (level_o),
    .underrun_o  (underrun_o),
    .late_o      (late_o),
    .flags_clr_i (flags_clr_i),
    .busy_o      (busy_o)
  );

  always #5 pclk_i = ~pclk_i;

  int n_total = 0;
  int n_pass  = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk_i);
      #1;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (smp_valid_o !== 1'b1 && n < max);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"},    32'(level_o), 0);
    check({tag, "_wr_ready"}, 32'(wr_ready_o), 1);
    check({tag, "_valid"},    32'(smp_valid_o), 0);
    check({tag, "_data"},     32'(smp_data_o), 0);
    check({tag, "_underrun"}, 32'(underrun_o), 0);
    check({tag, "_late"},     32'(late_o), 0);
    check({tag, "_busy"},     32'(busy_o), 0);
  endtask

  // handshake monitor: a sample is consumed when valid and ready meet at the next edge
  always @(negedge pclk_i) begin
    if (prst_i === 1'b0 && smp_valid_o === 1'b1 && smp_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_sample: got 0x%0h, expected none", smp_data_o);
      end else begin
        check("sample_data", 32'(smp_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hits;
    logic stable;
    logic [DATA_W-1:0] pcm [3];
    pcm[0] = 8'h10; pcm[1] = 8'h20; pcm[2] = 8'h30;

    prst_i = 1'b1; en_i = 1'b0; flush_i = 1'b0; div_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; smp_ready_i = 1'b0; flags_clr_i = 1'b0;
    step(2);
    prst_i = 1'b0;
    step(1);
    check_reset_vals("reset");

    // paced stream, consumer always ready
    div_i = 16'd9; smp_ready_i = 1'b1;
    wr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data_i = pcm[i];
      exp_q.push_back(pcm[i]);
      step(1);
    end
    wr_valid_i = 1'b0;
    check("stream_level", 32'(level_o), 3);
    en_i = 1'b1;
    wait_valid(20, n);
    check("first_tick_latency", n, 11);
    for (int k = 0; k < 2; k++) begin
      wait_valid(20, n);
      check("tick_period", n, 10);
    end
    step(9);
    check("underrun_before_4th_tick", 32'(underrun_o), 0);
    step(1);
    check("underrun_at_4th_tick", 32'(underrun_o), 1);
    hits = 0;
    repeat (12) begin
      step(1);
      if (smp_valid_o) hits++;
    end
    check("no_valid_after_underrun", hits, 0);
    check("stream_drained", exp_q.size(), 0);
    en_i = 1'b0; smp_ready_i = 1'b0; flags_clr_i = 1'b1;
    step(1);
    flags_clr_i = 1'b0;
    check("underrun_cleared", 32'(underrun_o), 0);

    // fill beyond capacity with the pacer idle
    wr_valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data_i = 8'(8'hA0 + i);
      if (i < DEPTH) exp_q.push_back(wr_data_i);
      step(1);
    end
    wr_valid_i = 1'b0;
    check("full_level", 32'(level_o), 16);
    check("full_wr_ready", 32'(wr_ready_o), 0);
    div_i = 16'd0; en_i = 1'b1;
    wait_valid(10, n);
    check("div0_latency", n, 2);
    smp_ready_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'hC0;
    step(1);
    smp_ready_i = 1'b0; wr_valid_i = 1'b0; en_i = 1'b0;
    check("push_into_full_dropped", 32'(level_o), 15);
    step(1);
    en_i = 1'b1;
    wait_valid(10, n);
    smp_ready_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'hC1;
    exp_q.push_back(8'hC1);
    step(1);
    smp_ready_i = 1'b0; wr_valid_i = 1'b0; en_i = 1'b0;
    check("push_pop_same_cycle", 32'(level_o), 15);
    check("not_full_wr_ready", 32'(wr_ready_o), 1);
    step(1);
    flags_clr_i = 1'b1;
    step(1);
    flags_clr_i = 1'b0;
    check("late_cleared_pre_slow", 32'(late_o), 0);

    // slow consumer
    div_i = 16'd3; en_i = 1'b1;
    wait_valid(10, n);
    check("div3_latency", n, 5);
    check("slow_head", 32'(smp_data_o), 32'h A2);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (smp_valid_o !== 1'b1 || smp_data_o !== 8'hA2) stable = 1'b0;
      if (i == 2) check("late_before_tick", 32'(late_o), 0);
    end
    check("offer_stable", 32'(stable), 1);
    check("late_set", 32'(late_o), 1);
    smp_ready_i = 1'b1;
    step(1);
    smp_ready_i = 1'b0; en_i = 1'b0;
    check("one_pop", 32'(level_o), 14);
    step(2);
    check("one_pop_hold", 32'(level_o), 14);
    flags_clr_i = 1'b1;
    step(1);
    flags_clr_i = 1'b0;
    check("late_cleared", 32'(late_o), 0);

    // abort an offer with en_i, then re-enable
    div_i = 16'd9; en_i = 1'b1;
    wait_valid(20, n);
    check("abort_first_latency", n, 11);
    check("abort_head", 32'(smp_data_o), 32'h A3);
    en_i = 1'b0;
    step(1);
    check("abort_valid_drop", 32'(smp_valid_o), 0);
    check("abort_level_kept", 32'(level_o), 14);
    step(2);
    en_i = 1'b1;
    wait_valid(20, n);
    check("reenable_latency", n, 11);
    check("reenable_head", 32'(smp_data_o), 32'h A3);

    // flush during an offer, then reset over sticky flags
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    exp_q.delete();
    check("flush_level", 32'(level_o), 0);
    check("flush_valid", 32'(smp_valid_o), 0);
    check("flush_busy", 32'(busy_o), 1);
    check("flush_wr_ready", 32'(wr_ready_o), 1);
    n = 0;
    while (underrun_o !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check("underrun_after_flush", 32'(underrun_o), 1);
    prst_i = 1'b1;
    step(1);
    check_reset_vals("reset_mid_run");
    prst_i = 1'b0; en_i = 1'b0;
    step(1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
